// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch, decode and the register-file wrapper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCREMENT       = 32'd4;
    localparam logic [31:0] DEF_RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_READ_OFFSET = 32'd8;
    localparam logic [31:0] WORD_MASK          = 32'h0000_0003;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~WORD_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_buffer.sv
// Single-entry instruction holding register between fetch and decode.
// clear beats load; hold freezes the entry against loads.
module fetch_buffer
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    // Capture a returned word, or drop the valid flag on flush/consume.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= '0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i && !hold_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the fetch PC and the instruction-memory handshake.
// Presents one instruction to decode and drives R15 (PROGCOUNT).
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
    parameter logic [31:0] PC_READ_OFFSET = DEF_PC_READ_OFFSET
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR_PC,
    output logic [31:0] PROGCOUNT
);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_d;

    logic slot_busy;
    logic consume;
    logic accept;
    logic buf_load;
    logic buf_clear;
    logic buf_hold;

    // Request is a pure decode of the state register.
    assign IMEM_REQ  = (state_q == FETCH);
    assign IMEM_ADDR = fetch_pc_q;

    // Slot occupied and decode refusing it: returned data has nowhere to go.
    assign slot_busy = INSTR_VALID && STALL;
    assign consume   = INSTR_VALID && !STALL;
    assign accept    = IMEM_REQ && IMEM_ACK && !BRANCH && !slot_busy;

    assign buf_load  = accept;
    assign buf_clear = BRANCH || (consume && !accept);
    assign buf_hold  = (state_q == HOLD);

    // Next fetch address: redirect, sequential advance, or keep.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (BRANCH) begin
            fetch_pc_d = word_align(BRANCH_TARGET);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_INCREMENT;
        end
    end

    // Fetch address register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Fetch FSM; a redirect always restarts fetching.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else if (BRANCH) begin
            state_q <= FETCH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (slot_busy) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fetch_buffer #(
        .RESET_PC (RESET_PC)
    ) u_fetch_buffer (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .hold_i  (buf_hold),
        .instr_i (IMEM_DATA),
        .pc_i    (fetch_pc_q),
        .instr_o (INSTR),
        .pc_o    (INSTR_PC),
        .valid_o (INSTR_VALID)
    );

    // R15 reads see the ARM pipeline offset.
    assign PROGCOUNT = INSTR_PC + PC_READ_OFFSET;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_DATA = '0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic [31:0] INSTR_PC;
    logic [31:0] PROGCOUNT;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 fetching, 2 holding.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;

    pc_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH        (BRANCH),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_ACK      (IMEM_ACK),
        .IMEM_DATA     (IMEM_DATA),
        .INSTR         (INSTR),
        .INSTR_VALID   (INSTR_VALID),
        .INSTR_PC      (INSTR_PC),
        .PROGCOUNT     (PROGCOUNT)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Advance model and DUT by one clock using the inputs now applied.
    task automatic tick();
        int          nphase;
        logic [31:0] npc;
        logic [31:0] ninstr;
        logic [31:0] nipc;
        logic        nvalid;
        nphase = m_phase;
        npc    = m_pc;
        ninstr = m_instr;
        nipc   = m_ipc;
        nvalid = m_valid;
        if (BRANCH) begin
            npc    = {BRANCH_TARGET[31:2], 2'b00};
            nvalid = 1'b0;
            nphase = 1;
        end else if (m_phase == 0) begin
            nphase = 1;
        end else if (m_phase == 1) begin
            if (m_valid && STALL) begin
                nphase = 2;
            end else if (IMEM_ACK) begin
                ninstr = IMEM_DATA;
                nipc   = m_pc;
                nvalid = 1'b1;
                npc    = m_pc + 32'd4;
            end else begin
                nvalid = 1'b0;
            end
        end else begin
            if (!STALL) begin
                nvalid = 1'b0;
                nphase = 1;
            end
        end
        @(posedge CLK);
        #1;
        m_phase = nphase;
        m_pc    = npc;
        m_instr = ninstr;
        m_ipc   = nipc;
        m_valid = nvalid;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        STALL    = 1'b0;
        BRANCH   = 1'b0;
        IMEM_ACK = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        vectors++;
        if (IMEM_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req got %b exp 0", IMEM_REQ);
        end
        vectors++;
        if (IMEM_ADDR !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr got %h exp 0", IMEM_ADDR);
        end
        vectors++;
        if (INSTR_VALID !== 1'b0 || INSTR !== 32'h0 || INSTR_PC !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_buf got v=%b i=%h pc=%h exp 0/0/0",
                     INSTR_VALID, INSTR, INSTR_PC);
        end
        vectors++;
        if (PROGCOUNT !== 32'h8) begin
            miscompares++;
            $display("FAIL reset_progcount got %h exp 8", PROGCOUNT);
        end
        do_reset();
        @(negedge CLK);
        vectors++;
        if (IMEM_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL release_idle_req got %b exp 0", IMEM_REQ);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (IMEM_REQ !== 1'b1) begin
            miscompares++;
            $display("FAIL release_first_req got %b exp 1", IMEM_REQ);
        end
    endtask

    task automatic test_stream();
        logic [31:0] prev;
        logic [31:0] cur;
        do_reset();
        IMEM_ACK = 1'b1;
        tick();
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            cur = $urandom;
            IMEM_DATA = cur;
            @(negedge CLK);
            vectors++;
            if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL stream_addr[%0d] got req=%b %h exp 1 %h",
                         i, IMEM_REQ, IMEM_ADDR, 32'(i * 4));
            end
            if (i > 0) begin
                vectors++;
                if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'((i - 1) * 4)
                    || INSTR !== prev) begin
                    miscompares++;
                    $display("FAIL stream_instr[%0d] got v=%b pc=%h i=%h exp 1 %h %h",
                             i, INSTR_VALID, INSTR_PC, INSTR,
                             32'((i - 1) * 4), prev);
                end
                vectors++;
                if (PROGCOUNT !== 32'((i - 1) * 4 + 8)) begin
                    miscompares++;
                    $display("FAIL stream_progcount[%0d] got %h exp %h",
                             i, PROGCOUNT, 32'((i - 1) * 4 + 8));
                end
            end
            prev = cur;
            tick();
        end
    endtask

    task automatic test_ack_wait();
        logic [31:0] d1;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h0000_000C;
        tick();
        BRANCH = 1'b0;
        IMEM_ACK = 1'b1;
        IMEM_DATA = $urandom;
        tick();
        IMEM_ACK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            vectors++;
            if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h10) begin
                miscompares++;
                $display("FAIL wait_req[%0d] got %b %h exp 1 00000010",
                         k, IMEM_REQ, IMEM_ADDR);
            end
            vectors++;
            if (INSTR_VALID !== (k == 0)) begin
                miscompares++;
                $display("FAIL wait_valid[%0d] got %b exp %b",
                         k, INSTR_VALID, (k == 0));
            end
            tick();
        end
        d1 = $urandom;
        IMEM_ACK = 1'b1;
        IMEM_DATA = d1;
        tick();
        IMEM_ACK = 1'b0;
        @(negedge CLK);
        vectors++;
        if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h10 || INSTR !== d1) begin
            miscompares++;
            $display("FAIL wait_arrive got v=%b pc=%h i=%h exp 1 00000010 %h",
                     INSTR_VALID, INSTR_PC, INSTR, d1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h0000_0020;
        tick();
        BRANCH = 1'b0;
        d = $urandom;
        IMEM_ACK = 1'b1;
        IMEM_DATA = d;
        tick();
        STALL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) STALL = 1'b0;
            IMEM_DATA = $urandom;
            @(negedge CLK);
            vectors++;
            if (INSTR_VALID !== 1'b1 || INSTR !== d || INSTR_PC !== 32'h20) begin
                miscompares++;
                $display("FAIL stall_frozen[%0d] got v=%b i=%h pc=%h exp 1 %h 00000020",
                         k, INSTR_VALID, INSTR, INSTR_PC, d);
            end
            if (k > 0) begin
                vectors++;
                if (IMEM_REQ !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold_req[%0d] got %b exp 0", k, IMEM_REQ);
                end
            end
            tick();
        end
        @(negedge CLK);
        vectors++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h24) begin
            miscompares++;
            $display("FAIL stall_resume got %b %h exp 1 00000024",
                     IMEM_REQ, IMEM_ADDR);
        end
        tick();
    endtask

    task automatic test_branch_ack();
        IMEM_ACK = 1'b1;
        STALL = 1'b0;
        IMEM_DATA = $urandom;
        tick();
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'h0000_1003;
        IMEM_DATA = 32'hDEAD_BEEF;
        tick();
        BRANCH = 1'b0;
        @(negedge CLK);
        vectors++;
        if (INSTR_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_flush got %b exp 0", INSTR_VALID);
        end
        vectors++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL branch_addr got %b %h exp 1 00001000",
                     IMEM_REQ, IMEM_ADDR);
        end
        tick();
    endtask

    task automatic test_wrap();
        BRANCH = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        tick();
        BRANCH = 1'b0;
        IMEM_ACK = 1'b1;
        IMEM_DATA = $urandom;
        @(negedge CLK);
        vectors++;
        if (IMEM_ADDR !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_pre got %h exp fffffffc", IMEM_ADDR);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (IMEM_ADDR !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_addr got %h exp 0", IMEM_ADDR);
        end
        vectors++;
        if (INSTR_PC !== 32'hFFFF_FFFC || PROGCOUNT !== 32'h4) begin
            miscompares++;
            $display("FAIL wrap_progcount got pc=%h r15=%h exp fffffffc 00000004",
                     INSTR_PC, PROGCOUNT);
        end
    endtask

    task automatic test_async_reset();
        IMEM_ACK = 1'b1;
        STALL = 1'b0;
        IMEM_DATA = $urandom;
        tick();
        #2;
        vectors++;
        if (IMEM_REQ !== 1'b1 || INSTR_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre got req=%b v=%b exp 1 1",
                     IMEM_REQ, INSTR_VALID);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_drop got req=%b v=%b exp 0 0",
                     IMEM_REQ, INSTR_VALID);
        end
        vectors++;
        if (IMEM_ADDR !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_addr got %h exp 0", IMEM_ADDR);
        end
        do_reset();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            STALL     = ($urandom_range(0, 99) < 30);
            BRANCH    = ($urandom_range(0, 99) < 5);
            IMEM_ACK  = ($urandom_range(0, 99) < 60);
            IMEM_DATA = $urandom;
            r = $urandom_range(0, 3);
            if (r == 0) BRANCH_TARGET = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else BRANCH_TARGET = $urandom;
            @(negedge CLK);
            vectors++;
            if (IMEM_REQ !== (m_phase == 1) || IMEM_ADDR !== m_pc) begin
                miscompares++;
                $display("FAIL rand_req[%0d] got %b %h exp %b %h",
                         c, IMEM_REQ, IMEM_ADDR, (m_phase == 1), m_pc);
            end
            vectors++;
            if (INSTR_VALID !== m_valid) begin
                miscompares++;
                $display("FAIL rand_valid[%0d] got %b exp %b",
                         c, INSTR_VALID, m_valid);
            end
            if (m_valid) begin
                vectors++;
                if (INSTR !== m_instr || INSTR_PC !== m_ipc
                    || PROGCOUNT !== m_ipc + 32'd8) begin
                    miscompares++;
                    $display("FAIL rand_instr[%0d] got %h %h %h exp %h %h %h",
                             c, INSTR, INSTR_PC, PROGCOUNT,
                             m_instr, m_ipc, m_ipc + 32'd8);
                end
            end
            tick();
        end
        STALL = 1'b0;
        BRANCH = 1'b0;
        IMEM_ACK = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_ack_wait();
        test_stall();
        test_branch_ack();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
